// File: rtl/hbridge_multi_driver.sv
// Multi-channel signed-PWM H-bridge driver.
// All channels share one PWM timebase. Each channel has its own enable, takes a
// new duty value only at a period boundary, and inserts a coast (dead) interval
// whenever the drive direction reverses.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | channel disabled or not yet started; bridge coasts (all pins 0)
// DRIVE  | bridge driven in direction dir, PWM high while cnt < mag
// DEAD   | direction reversal in progress; bridge coasts for DEAD_TICKS ticks
module hbridge_multi_driver #(
  parameter int CHANNELS   = 2,
  parameter int WIDTH      = 10,
  parameter int DEAD_TICKS = 16
) (
  input  logic                      clk_in,
  input  logic                      reset,
  input  logic                      ce_in,
  input  logic [CHANNELS*WIDTH-1:0] duty_in,
  input  logic [CHANNELS-1:0]       enable_in,
  output logic [CHANNELS-1:0]       pwm_out,
  output logic [CHANNELS-1:0]       ina_out,
  output logic [CHANNELS-1:0]       inb_out,
  output logic [CHANNELS-1:0]       reversing_out,
  output logic                      period_start_out
);

  localparam int CW  = WIDTH - 1;
  localparam int DCW = (DEAD_TICKS > 0) ? $clog2(DEAD_TICKS + 1) : 1;

  // Last count value of a period; the period is therefore 2^CW - 1 ticks long,
  // which lets the all-ones magnitude hold the PWM high for the whole period.
  localparam logic [CW-1:0]  LAST      = {{(CW-1){1'b1}}, 1'b0};
  localparam logic [CW-1:0]  MAG_MAX   = {CW{1'b1}};
  localparam logic [DCW-1:0] DEAD_LOAD = DCW'(DEAD_TICKS);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_DEAD  = 2'd2
  } state_t;

  logic [CW-1:0] cnt;
  logic          bnd;

  // Period boundary: the tick that wraps the timebase back to zero.
  assign bnd = ce_in && (cnt == LAST);

  // Shared PWM timebase.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (ce_in) begin
      cnt <= bnd ? '0 : cnt + CW'(1);
    end
  end

  // Period-start strobe, one clk after the boundary tick.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      period_start_out <= 1'b0;
    end else begin
      period_start_out <= bnd;
    end
  end

  for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
    logic [WIDTH-1:0] duty;
    logic             sgn;
    logic [CW-1:0]    duty_low;
    logic [CW-1:0]    new_mag;
    logic             expire;

    state_t           state_q, state_d;
    logic [CW-1:0]    mag_q, mag_d;
    logic [CW-1:0]    pend_mag_q, pend_mag_d;
    logic             dir_q, dir_d;
    logic             pend_dir_q, pend_dir_d;
    logic [DCW-1:0]   dcnt_q, dcnt_d;

    logic             drive;
    logic             pwm_d, ina_d, inb_d, rev_d;
    logic             pwm_q, ina_q, inb_q, rev_q;

    assign duty     = duty_in[k*WIDTH +: WIDTH];
    assign sgn      = duty[WIDTH-1];
    assign duty_low = duty[CW-1:0];

    // |duty|; the most negative code has no positive twin and saturates to full scale.
    assign new_mag = !sgn              ? duty_low :
                     (duty_low == '0)  ? MAG_MAX  :
                                         (~duty_low + CW'(1));

    // Dead interval ends on the tick that would take the counter to zero.
    assign expire = ce_in && (dcnt_q == DCW'(1));

    // Channel state register.
    always_ff @(posedge clk_in or posedge reset) begin
      if (reset) begin
        state_q    <= ST_IDLE;
        mag_q      <= '0;
        dir_q      <= 1'b0;
        pend_mag_q <= '0;
        pend_dir_q <= 1'b0;
        dcnt_q     <= '0;
      end else begin
        state_q    <= state_d;
        mag_q      <= mag_d;
        dir_q      <= dir_d;
        pend_mag_q <= pend_mag_d;
        pend_dir_q <= pend_dir_d;
        dcnt_q     <= dcnt_d;
      end
    end

    // Next-state logic; disabling a channel overrides everything without waiting for a boundary.
    always_comb begin
      state_d    = state_q;
      mag_d      = mag_q;
      dir_d      = dir_q;
      pend_mag_d = pend_mag_q;
      pend_dir_d = pend_dir_q;
      dcnt_d     = dcnt_q;

      if (!enable_in[k]) begin
        state_d = ST_IDLE;
        mag_d   = '0;
        dcnt_d  = '0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (bnd) begin
              state_d = ST_DRIVE;
              mag_d   = new_mag;
              dir_d   = sgn;
            end
          end

          ST_DRIVE: begin
            if (bnd) begin
              if ((sgn == dir_q) || (new_mag == '0)) begin
                // Same direction, or zero drive: direction is kept.
                mag_d = new_mag;
              end else if (DEAD_TICKS == 0) begin
                mag_d = new_mag;
                dir_d = sgn;
              end else begin
                state_d    = ST_DEAD;
                pend_mag_d = new_mag;
                pend_dir_d = sgn;
                dcnt_d     = DEAD_LOAD;
              end
            end
          end

          ST_DEAD: begin
            if (ce_in) begin
              dcnt_d = dcnt_q - DCW'(1);
            end
            if (bnd && (sgn == dir_q)) begin
              // Reversal withdrawn before it completed: resume in the original direction.
              state_d    = ST_DRIVE;
              mag_d      = new_mag;
              pend_mag_d = new_mag;
              pend_dir_d = sgn;
              dcnt_d     = '0;
            end else if (bnd && expire) begin
              // Fresh boundary sample takes precedence over the older pending value.
              state_d    = ST_DRIVE;
              mag_d      = new_mag;
              dir_d      = sgn;
              pend_mag_d = new_mag;
              pend_dir_d = sgn;
            end else if (bnd) begin
              pend_mag_d = new_mag;
              pend_dir_d = sgn;
            end else if (expire) begin
              state_d = ST_DRIVE;
              mag_d   = pend_mag_q;
              dir_d   = pend_dir_q;
            end
          end

          default: begin
            state_d = ST_IDLE;
            mag_d   = '0;
            dcnt_d  = '0;
          end
        endcase
      end
    end

    // Pin values; gating with enable makes a disabled channel coast on the very next clk.
    always_comb begin
      drive = (state_q == ST_DRIVE) && enable_in[k];
      pwm_d = drive && (cnt < mag_q);
      ina_d = drive && dir_q;
      inb_d = drive && !dir_q;
      rev_d = (state_q == ST_DEAD) && enable_in[k];
    end

    // Registered pins.
    always_ff @(posedge clk_in or posedge reset) begin
      if (reset) begin
        pwm_q <= 1'b0;
        ina_q <= 1'b0;
        inb_q <= 1'b0;
        rev_q <= 1'b0;
      end else begin
        pwm_q <= pwm_d;
        ina_q <= ina_d;
        inb_q <= inb_d;
        rev_q <= rev_d;
      end
    end

    assign pwm_out[k]       = pwm_q;
    assign ina_out[k]       = ina_q;
    assign inb_out[k]       = inb_q;
    assign reversing_out[k] = rev_q;
  end

endmodule

// File: tb/tb_hbridge_multi_driver.sv
// Bench for hbridge_multi_driver: table of duty/enable vectors with expected
// per-period pin statistics, plus hand sequences for enable drop, async reset
// and a long dead interval that gets withdrawn at a boundary.
module tb_hbridge_multi_driver;

  localparam int CH = 2;
  localparam int W  = 10;
  localparam int P  = 511;

  logic          clk = 1'b0;
  logic          rst;
  logic          ce;
  logic [CH*W-1:0] duty;
  logic [CH-1:0] en;

  logic [CH-1:0] pwm, ina, inb, rev;
  logic          ps;
  logic [CH-1:0] pwm2, ina2, inb2, rev2;
  logic          ps2;

  always #5 clk = ~clk;

  hbridge_multi_driver #(.CHANNELS(CH), .WIDTH(W), .DEAD_TICKS(16)) dut (
    .clk_in(clk), .reset(rst), .ce_in(ce), .duty_in(duty), .enable_in(en),
    .pwm_out(pwm), .ina_out(ina), .inb_out(inb), .reversing_out(rev),
    .period_start_out(ps)
  );

  hbridge_multi_driver #(.CHANNELS(CH), .WIDTH(W), .DEAD_TICKS(600)) dut_long (
    .clk_in(clk), .reset(rst), .ce_in(ce), .duty_in(duty), .enable_in(en),
    .pwm_out(pwm2), .ina_out(ina2), .inb_out(inb2), .reversing_out(rev2),
    .period_start_out(ps2)
  );

  typedef struct {
    int d0; logic e0; int d1; logic e1;
    int pwm0; int ina0; int inb0; int rev0;
    int pwm1; int ina1; int inb1; int rev1;
  } vec_t;

  typedef struct {
    int pwm0; int ina0; int inb0; int rev0;
    int pwm1; int ina1; int inb1; int rev1;
    int lpwm; int lina; int linb; int lrev;
    int ps;
  } meas_t;

  int   checks = 0;
  int   errors = 0;
  vec_t vecs[8];
  vec_t sb[$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Wait for the next period-start strobe, bounded.
  task automatic wait_pulse();
    bit seen = 0;
    for (int i = 0; i < 2000 && !seen; i++) begin
      @(negedge clk);
      if (ps) seen = 1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL period_start_timeout: got no pulse expected pulse within 2000 clks");
    end
  endtask

  // Collect pin statistics over the full period that follows the next boundary.
  task automatic measure(output meas_t m);
    m = '{default: 0};
    wait_pulse();
    for (int i = 0; i < P; i++) begin
      @(negedge clk);
      m.pwm0 += int'(pwm[0]); m.ina0 += int'(ina[0]);
      m.inb0 += int'(inb[0]); m.rev0 += int'(rev[0]);
      m.pwm1 += int'(pwm[1]); m.ina1 += int'(ina[1]);
      m.inb1 += int'(inb[1]); m.rev1 += int'(rev[1]);
      m.lpwm += int'(pwm2[0]); m.lina += int'(ina2[0]);
      m.linb += int'(inb2[0]); m.lrev += int'(rev2[0]);
      m.ps   += int'(ps);
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    meas_t m;
    vec_t  e;

    //        d0    e0  d1    e1  pwm0 ina0 inb0 rev0  pwm1 ina1 inb1 rev1
    vecs[0] = '{ 100, 1,  -50, 1,  100,   0, 511,   0,   50, 511,   0,   0};
    vecs[1] = '{-512, 1,  -50, 1,  495, 495,   0,  16,   50, 511,   0,   0};
    vecs[2] = '{-512, 1,  300, 1,  511, 511,   0,   0,  284,   0, 495,  16};
    vecs[3] = '{   0, 1,  300, 1,    0, 511,   0,   0,  300,   0, 511,   0};
    vecs[4] = '{ 200, 1,  300, 0,  184,   0, 495,  16,    0,   0,   0,   0};
    vecs[5] = '{-200, 1,  300, 0,  184, 495,   0,  16,    0,   0,   0,   0};
    vecs[6] = '{-200, 1,  511, 1,  200, 511,   0,   0,  511,   0, 511,   0};
    vecs[7] = '{   1, 1,   -1, 1,    0,   0, 495,  16,    0, 495,   0,  16};

    rst = 1'b1; ce = 1'b1; duty = '0; en = '0;
    repeat (3) @(negedge clk);
    check("reset_pwm", int'(pwm), 0);
    check("reset_ina", int'(ina), 0);
    check("reset_inb", int'(inb), 0);
    check("reset_rev", int'(rev), 0);
    check("reset_ps",  int'(ps),  0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      duty = {W'(vecs[i].d1), W'(vecs[i].d0)};
      en   = {vecs[i].e1, vecs[i].e0};
      sb.push_back(vecs[i]);
      repeat (100) @(negedge clk);
      measure(m);
      e = sb.pop_front();
      check($sformatf("v%0d_pwm0", i), m.pwm0, e.pwm0);
      check($sformatf("v%0d_ina0", i), m.ina0, e.ina0);
      check($sformatf("v%0d_inb0", i), m.inb0, e.inb0);
      check($sformatf("v%0d_rev0", i), m.rev0, e.rev0);
      check($sformatf("v%0d_pwm1", i), m.pwm1, e.pwm1);
      check($sformatf("v%0d_ina1", i), m.ina1, e.ina1);
      check($sformatf("v%0d_inb1", i), m.inb1, e.inb1);
      check($sformatf("v%0d_rev1", i), m.rev1, e.rev1);
      check($sformatf("v%0d_period_starts", i), m.ps, 1);
    end

    // Enable drop mid-pulse on ch1 while ch0 keeps driving.
    duty = {W'(300), W'(300)};
    wait_pulse();
    repeat (40) @(negedge clk);
    check("pre_drop_pwm1", int'(pwm[1]), 1);
    check("pre_drop_pwm0", int'(pwm[0]), 1);
    en[1] = 1'b0;
    @(posedge clk); #1;
    check("drop_pwm1", int'(pwm[1]), 0);
    check("drop_ina1", int'(ina[1]), 0);
    check("drop_inb1", int'(inb[1]), 0);
    check("drop_pwm0", int'(pwm[0]), 1);
    check("drop_inb0", int'(inb[0]), 1);

    // Asynchronous reset in the middle of a dead interval.
    duty[W-1:0] = W'(-300);
    wait_pulse();
    repeat (5) @(negedge clk);
    check("dead_rev0", int'(rev[0]), 1);
    check("dead_pwm0", int'(pwm[0]), 0);
    check("dead_ina0", int'(ina[0]), 0);
    check("dead_inb0", int'(inb[0]), 0);
    #1 rst = 1'b1;
    #1;
    check("async_rst_pwm", int'({pwm, pwm2}), 0);
    check("async_rst_ina", int'({ina, ina2}), 0);
    check("async_rst_inb", int'({inb, inb2}), 0);
    check("async_rst_rev", int'({rev, rev2}), 0);
    check("async_rst_ps",  int'({ps, ps2}), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Long dead interval withdrawn at the next boundary.
    duty = {W'(0), W'(200)};
    en   = 2'b01;
    repeat (100) @(negedge clk);
    wait_pulse();
    repeat (100) @(negedge clk);
    duty[W-1:0] = W'(-200);
    wait_pulse();
    repeat (100) @(negedge clk);
    check("long_dead_rev0", int'(rev2[0]), 1);
    check("long_dead_pwm0", int'(pwm2[0]), 0);
    check("long_dead_ina0", int'(ina2[0]), 0);
    check("long_dead_inb0", int'(inb2[0]), 0);
    check("short_dead_done_ina0", int'(ina[0]), 1);
    duty[W-1:0] = W'(200);
    measure(m);
    check("abort_pwm0", m.lpwm, 200);
    check("abort_ina0", m.lina, 0);
    check("abort_inb0", m.linb, P);
    check("abort_rev0", m.lrev, 0);
    check("short_rev0", m.rev0, 16);
    check("short_pwm0", m.pwm0, 184);
    check("abort_period_starts", m.ps, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
